simd_logic_imm_pipe: RTL
========================

SIMD_LOGIC_IMM_PIPE -- requirements
Module: simd_logic_imm_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 128, quadword width; a multiple of 32.
REQ-002 SHALL have parameter IMM_W, default 10, immediate field width.
REQ-003 SHALL have parameter LAT, default 2, pipeline depth in stages; legal range 1..4.
REQ-004 SHALL have parameter TAG_W, default 7, opaque tag width.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit, request present.
REQ-008 SHALL have port in_ready, output, 1 bit, request accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port op, input, 3 bits: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 EQV; 6 and 7 reserved.
REQ-010 SHALL have port esz, input, 2 bits: 0 byte, 1 halfword, 2 word; 3 reserved.
REQ-011 SHALL have port ra, input, DATA_W bits, [0:DATA_W-1], bit 0 MSB.
REQ-012 SHALL have port imme, input, IMM_W bits, [0:IMM_W-1], bit 0 MSB.
REQ-013 SHALL have port in_tag, input, TAG_W bits, passed through unchanged.
REQ-014 SHALL have port flush, input, 1 bit, synchronous pipeline kill.
REQ-015 SHALL have port out_valid, output, 1 bit, result present.
REQ-016 SHALL have port out_ready, input, 1 bit, consumer accepts.
REQ-017 SHALL have port result, output, DATA_W bits, [0:DATA_W-1].
REQ-018 SHALL have port out_tag, output, TAG_W bits.
REQ-019 SHALL have port out_err, output, 1 bit, high with a result whose op or esz was reserved.

Function
REQ-020 SHALL expand the immediate per element: byte uses imme[IMM_W-8:IMM_W-1] unextended; halfword sign-extends imme to 16 bits; word sign-extends imme to 32 bits.
REQ-021 SHALL replicate the expanded immediate t across every element slot of ra, from bit 0 upward.
REQ-022 SHALL compute result per bit as ra op t; NAND, NOR and EQV are the complements of AND, OR and XOR.
REQ-023 SHALL drive result all zeros and out_err=1 for a reserved op or esz; otherwise out_err=0.
REQ-024 SHALL register operands at stage 1 and present results from stage LAT, giving latency exactly LAT cycles from acceptance to out_valid when there is no backpressure.
REQ-025 SHALL advance stage k when it is empty or when stage k+1 advances; the last stage advances on out_ready.
REQ-026 SHALL drive in_ready = !flush && (stage 1 empty || stage 1 advancing), combinationally.
REQ-027 SHALL sustain one accepted request per cycle with out_ready held high.
REQ-028 SHALL hold result, out_tag and out_err stable while out_valid=1 and out_ready=0.
REQ-029 SHALL clear all stage valids on the clock edge after flush=1; no accept occurs in a flush cycle, and an output handshake in that cycle still completes.
REQ-030 SHALL preserve request order; no drops or duplication except through flush.

Reset
REQ-031 SHALL, while rst_n=0, clear all stage valids: out_valid=0, result=0, out_tag=0, out_err=0.
REQ-032 SHALL drive in_ready=0 while rst_n=0, and SHALL drive in_ready=1 from the first edge after rst_n is released.
REQ-033 SHALL discard any in-flight request when reset is asserted mid-operation; none emerges after release.

Structure
REQ-034 SHALL take opcode and esz encodings and the constants LAT_MAX=4 from the shared package fx1_pkg.
REQ-035 SHALL build the pipeline from one sub-module, simd_logic_pipe_stage: a valid/data register slice with ready-chaining, instantiated LAT times.
REQ-036 SHALL keep the compute logic combinational ahead of stage 1.

Verification
REQ-037 Directed test: op=AND, esz=1, imme=10'h3F0, ra=all 16'hFFFF -> each halfword 16'hFFF0 after LAT cycles.
REQ-038 Directed test: op=XOR, esz=0, imme=10'h2A5, ra=0 -> every byte 8'hA5; with esz=2 -> every word 32'hFFFFFEA5.
REQ-039 Directed test: stream of 8 requests with out_ready low for 3 cycles mid-stream -> in-order tags, no loss, result stable while stalled, in_ready low once full.
REQ-040 Directed test: flush asserted with LAT requests in flight -> out_valid=0 next cycle, no stale output after.
REQ-041 Directed test: op=6 or esz=3 -> result=0, out_err=1, tag preserved.
REQ-042 Directed test: rst_n pulsed low asynchronously mid-stream -> outputs zero immediately, in_ready=1 one edge after release.

Source files
------------

// File: rtl/fx1_pkg.sv
// rtl/fx1_pkg.sv - shared opcode/element-size encodings and pipeline limits
package fx1_pkg;

  localparam int LAT_MAX = 4;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_EQV  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ESZ_B = 2'd0,
    ESZ_H = 2'd1,
    ESZ_W = 2'd2
  } esz_e;

  function automatic logic op_reserved(input logic [2:0] op);
    return op > 3'(OP_EQV);
  endfunction

  function automatic logic esz_reserved(input logic [1:0] esz);
    return esz > 2'(ESZ_W);
  endfunction

endpackage

// File: rtl/simd_logic_pipe_stage.sv
// rtl/simd_logic_pipe_stage.sv - valid/data register slice with ready chaining
module simd_logic_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         vld;
  logic [W-1:0] dat;

  // The slice loads whenever it is empty or its contents move downstream.
  assign in_ready  = !vld || out_ready;
  assign out_valid = vld;
  assign out_data  = dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (in_ready) begin
      vld <= in_valid;
      if (in_valid) begin
        dat <= in_data;
      end
    end
  end

endmodule

// File: rtl/simd_logic_imm_pipe.sv
// rtl/simd_logic_imm_pipe.sv - SIMD logical op of a quadword with a replicated immediate
module simd_logic_imm_pipe
  import fx1_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int IMM_W  = 10,
  parameter int LAT    = 2,
  parameter int TAG_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [1:0]        esz,
  input  logic [0:DATA_W-1] ra,
  input  logic [0:IMM_W-1]  imme,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:DATA_W-1] result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  localparam int STAGES = (LAT > LAT_MAX) ? LAT_MAX : ((LAT < 1) ? 1 : LAT);
  localparam int SW     = DATA_W + TAG_W + 1;

  // Big-endian ports are re-viewed with the MSB on the left index.
  logic [IMM_W-1:0]  imm_v;
  logic [DATA_W-1:0] ra_v;
  logic [31:0]       t_w;
  logic [DATA_W-1:0] t_rep;
  logic [DATA_W-1:0] res;
  logic              err;

  assign imm_v = imme;
  assign ra_v  = ra;
  assign t_w   = 32'($signed(imm_v));

  always_comb begin
    t_rep = '0;
    res   = '0;
    err   = op_reserved(op) || esz_reserved(esz);
    case (esz)
      ESZ_B:   t_rep = {(DATA_W/8){imm_v[7:0]}};
      ESZ_H:   t_rep = {(DATA_W/16){t_w[15:0]}};
      ESZ_W:   t_rep = {(DATA_W/32){t_w}};
      default: t_rep = '0;
    endcase
    case (op)
      OP_AND:  res = ra_v & t_rep;
      OP_OR:   res = ra_v | t_rep;
      OP_XOR:  res = ra_v ^ t_rep;
      OP_NAND: res = ~(ra_v & t_rep);
      OP_NOR:  res = ~(ra_v | t_rep);
      OP_EQV:  res = ~(ra_v ^ t_rep);
      default: res = '0;
    endcase
    if (err) begin
      res = '0;
    end
  end

  // Holds in_ready low until the first edge after reset release.
  logic rst_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  logic          vld [0:STAGES];
  logic          rdy [0:STAGES];
  logic [SW-1:0] dat [0:STAGES];

  assign in_ready    = rst_done && !flush && rdy[0];
  assign vld[0]      = in_valid && in_ready;
  assign dat[0]      = {err, in_tag, res};
  assign rdy[STAGES] = out_ready;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    simd_logic_pipe_stage #(
      .W(SW)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (vld[g]),
      .in_data  (dat[g]),
      .in_ready (rdy[g]),
      .out_valid(vld[g+1]),
      .out_data (dat[g+1]),
      .out_ready(rdy[g+1])
    );
  end

  assign out_valid = vld[STAGES];
  assign result    = dat[STAGES][DATA_W-1:0];
  assign out_tag   = dat[STAGES][DATA_W +: TAG_W];
  assign out_err   = dat[STAGES][SW-1];

endmodule
